// File: rtl/vram_pkg.sv
// Shared types and default geometry for the character video RAM arbiter.
package vram_pkg;

  localparam int DEF_COLS        = 80;
  localparam int DEF_ROWS        = 30;
  localparam int DEF_CHAR_W_LOG2 = 3;
  localparam int DEF_CHAR_H_LOG2 = 4;
  localparam int DEF_ADDR_W      = 12;
  localparam logic [7:0] DEF_FILL = 8'h20;
  localparam int TEXT_SIZE       = DEF_COLS * DEF_ROWS;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } cpu_state_t;

endpackage

// File: rtl/vram_addr_gen.sv
// Maps the current pixel position plus scroll base to a wrapped character index.
module vram_addr_gen
  import vram_pkg::*;
#(
  parameter int COLS        = DEF_COLS,
  parameter int ROWS        = DEF_ROWS,
  parameter int CHAR_W_LOG2 = DEF_CHAR_W_LOG2,
  parameter int CHAR_H_LOG2 = DEF_CHAR_H_LOG2,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic [10:0]       disp_x,
  input  logic [10:0]       disp_y,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              out_of_area
);

  localparam int CW   = 11 - CHAR_W_LOG2;
  localparam int RW   = 11 - CHAR_H_LOG2;
  localparam int TEXT = COLS * ROWS;

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [ADDR_W:0] offset;
  logic [ADDR_W:0] sum;
  logic [ADDR_W:0] wrapped;
  logic            unused_low_bits;

  assign unused_low_bits = ^{disp_x[CHAR_W_LOG2-1:0], disp_y[CHAR_H_LOG2-1:0]};

  // Base and in-area offset are both below TEXT, so one subtraction wraps the sum.
  always_comb begin
    col         = disp_x[10:CHAR_W_LOG2];
    row         = disp_y[10:CHAR_H_LOG2];
    out_of_area = (32'(col) >= 32'(COLS)) || (32'(row) >= 32'(ROWS));
    offset      = (ADDR_W+1)'(32'(row) * 32'(COLS) + 32'(col));
    sum         = {1'b0, base} + offset;
    wrapped     = sum;
    if (sum >= (ADDR_W+1)'(TEXT))
      wrapped = sum - (ADDR_W+1)'(TEXT);
    addr        = wrapped[ADDR_W-1:0];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares a single-port 1-cycle-latency video RAM between display slots and a CPU port.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int         COLS        = DEF_COLS,
  parameter int         ROWS        = DEF_ROWS,
  parameter int         CHAR_W_LOG2 = DEF_CHAR_W_LOG2,
  parameter int         CHAR_H_LOG2 = DEF_CHAR_H_LOG2,
  parameter int         ADDR_W      = DEF_ADDR_W,
  parameter logic [7:0] FILL        = DEF_FILL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_active,
  input  logic [10:0]       disp_x,
  input  logic [10:0]       disp_y,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] scroll_base,
  output logic [7:0]        disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int TEXT = COLS * ROWS;

  cpu_state_t        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_oob;
  logic              slot;
  logic              cpu_addr_bad;
  logic              cpu_bad_q;
  logic              d1_valid, d1_fill;
  logic              d2_valid, d2_fill;

  assign slot         = disp_active && (disp_x[CHAR_W_LOG2-1:0] == '0);
  assign cpu_addr_bad = 32'(cpu_addr) >= 32'(TEXT);

  vram_addr_gen #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .CHAR_W_LOG2 (CHAR_W_LOG2),
    .CHAR_H_LOG2 (CHAR_H_LOG2),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .base        (base_q),
    .addr        (gen_addr),
    .out_of_area (gen_oob)
  );

  always_ff @(posedge clk) begin
    if (reset)
      base_q <= '0;
    else if (vblank)
      base_q <= (32'(scroll_base) >= 32'(TEXT)) ? '0 : scroll_base;
  end

  // Fill slots travel the same pipeline so FILL appears at the normal latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1_valid   <= 1'b0;
      d1_fill    <= 1'b0;
      d2_valid   <= 1'b0;
      d2_fill    <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      d1_valid   <= slot;
      d1_fill    <= gen_oob;
      d2_valid   <= d1_valid;
      d2_fill    <= d1_fill;
      disp_valid <= d2_valid;
      if (d2_valid)
        disp_data <= d2_fill ? FILL : ram_rdata;
    end
  end

  // CPU is only accepted outside slots, so display and CPU never claim the same RAM cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      cpu_bad_q <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= 8'h00;
    end else begin
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;
      if (slot && !gen_oob)
        ram_addr <= gen_addr;
      case (state)
        IDLE: begin
          if (cpu_req && !slot) begin
            state     <= ISSUE;
            ram_addr  <= cpu_addr;
            ram_we    <= cpu_we && !cpu_addr_bad;
            ram_wdata <= cpu_wdata;
            cpu_bad_q <= cpu_addr_bad;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          state     <= ACK;
          cpu_ack   <= 1'b1;
          cpu_rdata <= cpu_bad_q ? 8'h00 : ram_rdata;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
